// File: rtl/pop_sequence_monitor.sv
// Receive-side checker for the POP pulse train (pump, probe, MW, sample).
// Tracks the phase sequence, measures each phase width in clk cycles, flags
// illegal vectors and phase timeouts, and latches a width set per good cycle.
module pop_sequence_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pump_in,
    input  logic             probe_in,
    input  logic             MW_in,
    input  logic             sample_in,
    output logic [CNT_W-1:0] pump_width,
    output logic [CNT_W-1:0] mw1_width,
    output logic [CNT_W-1:0] free_width,
    output logic [CNT_W-1:0] mw2_width,
    output logic [CNT_W-1:0] probe_width,
    output logic [CNT_W-1:0] sample_width,
    output logic             cycle_valid,
    output logic             seq_error,
    output logic [7:0]       error_count,
    output logic [3:0]       fsm_state
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StPump   = 4'd1,
        StDark   = 4'd2,
        StMw1    = 4'd3,
        StFree   = 4'd4,
        StMw2    = 4'd5,
        StGap    = 4'd6,
        StDetect = 4'd7,
        StTail   = 4'd8
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // Vector encodings of {pump, probe, mw}
    localparam logic [2:0] VecNone  = 3'b000;
    localparam logic [2:0] VecMw    = 3'b001;
    localparam logic [2:0] VecProbe = 3'b010;
    localparam logic [2:0] VecPump  = 3'b100;

    logic [SYNC_STAGES-1:0] pump_sync_q, probe_sync_q, mw_sync_q, sample_sync_q;
    logic                   pump_prev_q;

    logic       p, r, m, s, p_rise;
    logic [2:0] vec;

    state_e state_q, state_d;
    logic   err, complete, start;

    logic [CNT_W-1:0] pump_cnt_q, pump_cnt_d;
    logic [CNT_W-1:0] mw1_cnt_q, mw1_cnt_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic [CNT_W-1:0] mw2_cnt_q, mw2_cnt_d;
    logic [CNT_W-1:0] probe_cnt_q, probe_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    // Dwell counter shared by DARK, GAP and TAIL; only used for timeout
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [CNT_W-1:0] pump_width_q, mw1_width_q, free_width_q;
    logic [CNT_W-1:0] mw2_width_q, probe_width_q, sample_width_q;
    logic             cycle_valid_q, seq_error_q;
    logic [7:0]       error_count_q;

    // Input synchronizers plus the previous synchronized pump for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pump_sync_q   <= '0;
            probe_sync_q  <= '0;
            mw_sync_q     <= '0;
            sample_sync_q <= '0;
            pump_prev_q   <= 1'b0;
        end else begin
            pump_sync_q   <= {pump_sync_q[SYNC_STAGES-2:0], pump_in};
            probe_sync_q  <= {probe_sync_q[SYNC_STAGES-2:0], probe_in};
            mw_sync_q     <= {mw_sync_q[SYNC_STAGES-2:0], MW_in};
            sample_sync_q <= {sample_sync_q[SYNC_STAGES-2:0], sample_in};
            pump_prev_q   <= pump_sync_q[SYNC_STAGES-1];
        end
    end

    assign p      = pump_sync_q[SYNC_STAGES-1];
    assign r      = probe_sync_q[SYNC_STAGES-1];
    assign m      = mw_sync_q[SYNC_STAGES-1];
    assign s      = sample_sync_q[SYNC_STAGES-1];
    assign p_rise = p & ~pump_prev_q;
    assign vec    = {p, r, m};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: legal stays/exits, timeouts, completion
    always_comb begin
        state_d  = state_q;
        err      = 1'b0;
        complete = 1'b0;
        start    = 1'b0;
        case (state_q)
            StIdle: begin
                // Anything other than a clean pump rise is ignored silently
                if (p_rise && vec == VecPump) begin
                    state_d = StPump;
                    start   = 1'b1;
                end
            end
            StPump: begin
                if (vec == VecPump) err = (pump_cnt_q == CntMax);
                else if (vec == VecNone) state_d = StDark;
                else err = 1'b1;
            end
            StDark: begin
                if (vec == VecNone) err = (dwell_cnt_q == CntMax);
                else if (vec == VecMw) state_d = StMw1;
                else err = 1'b1;
            end
            StMw1: begin
                if (vec == VecMw) err = (mw1_cnt_q == CntMax);
                else if (vec == VecNone) state_d = StFree;
                else err = 1'b1;
            end
            StFree: begin
                if (vec == VecNone) err = (free_cnt_q == CntMax);
                else if (vec == VecMw) state_d = StMw2;
                else err = 1'b1;
            end
            StMw2: begin
                if (vec == VecMw) err = (mw2_cnt_q == CntMax);
                else if (vec == VecNone) state_d = StGap;
                else if (vec == VecProbe) state_d = StDetect;
                else err = 1'b1;
            end
            StGap: begin
                if (vec == VecNone) err = (dwell_cnt_q == CntMax);
                else if (vec == VecProbe) state_d = StDetect;
                else err = 1'b1;
            end
            StDetect: begin
                if (vec == VecProbe) err = (probe_cnt_q == CntMax);
                else if (vec == VecNone) state_d = StTail;
                else if (vec == VecPump) complete = 1'b1;
                else err = 1'b1;
            end
            StTail: begin
                if (vec == VecNone) err = (dwell_cnt_q == CntMax);
                else if (vec == VecPump) complete = 1'b1;
                else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (complete) begin
            state_d = StPump;
            start   = 1'b1;
        end
        // Error wins over everything else
        if (err) begin
            state_d  = StIdle;
            complete = 1'b0;
            start    = 1'b0;
        end
    end

    // Phase counters: entry cycle loads 1, stay cycles increment
    always_comb begin
        pump_cnt_d   = pump_cnt_q;
        mw1_cnt_d    = mw1_cnt_q;
        free_cnt_d   = free_cnt_q;
        mw2_cnt_d    = mw2_cnt_q;
        probe_cnt_d  = probe_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (start) begin
            pump_cnt_d  = CntOne;
            mw1_cnt_d   = '0;
            free_cnt_d  = '0;
            mw2_cnt_d   = '0;
            probe_cnt_d = '0;
            dwell_cnt_d = '0;
        end else if (!err) begin
            if (state_d != state_q) begin
                case (state_d)
                    StDark, StGap, StTail: dwell_cnt_d = CntOne;
                    StMw1:                 mw1_cnt_d   = CntOne;
                    StFree:                free_cnt_d  = CntOne;
                    StMw2:                 mw2_cnt_d   = CntOne;
                    StDetect:              probe_cnt_d = CntOne;
                    default:               ;
                endcase
            end else begin
                case (state_q)
                    StPump:                pump_cnt_d  = pump_cnt_q + CntOne;
                    StDark, StGap, StTail: dwell_cnt_d = dwell_cnt_q + CntOne;
                    StMw1:                 mw1_cnt_d   = mw1_cnt_q + CntOne;
                    StFree:                free_cnt_d  = free_cnt_q + CntOne;
                    StMw2:                 mw2_cnt_d   = mw2_cnt_q + CntOne;
                    StDetect:              probe_cnt_d = probe_cnt_q + CntOne;
                    default:               ;
                endcase
            end
        end
        // Sample restarts on every pump rise taken, otherwise counts while active
        if (start) begin
            sample_cnt_d = {{(CNT_W-1){1'b0}}, s};
        end else if (state_q != StIdle && s && sample_cnt_q != CntMax) begin
            sample_cnt_d = sample_cnt_q + CntOne;
        end
    end

    // Counter, latched-width and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pump_cnt_q     <= '0;
            mw1_cnt_q      <= '0;
            free_cnt_q     <= '0;
            mw2_cnt_q      <= '0;
            probe_cnt_q    <= '0;
            dwell_cnt_q    <= '0;
            sample_cnt_q   <= '0;
            pump_width_q   <= '0;
            mw1_width_q    <= '0;
            free_width_q   <= '0;
            mw2_width_q    <= '0;
            probe_width_q  <= '0;
            sample_width_q <= '0;
            cycle_valid_q  <= 1'b0;
            seq_error_q    <= 1'b0;
            error_count_q  <= '0;
        end else begin
            pump_cnt_q    <= pump_cnt_d;
            mw1_cnt_q     <= mw1_cnt_d;
            free_cnt_q    <= free_cnt_d;
            mw2_cnt_q     <= mw2_cnt_d;
            probe_cnt_q   <= probe_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            cycle_valid_q <= complete;
            seq_error_q   <= err;
            if (complete) begin
                pump_width_q   <= pump_cnt_q;
                mw1_width_q    <= mw1_cnt_q;
                free_width_q   <= free_cnt_q;
                mw2_width_q    <= mw2_cnt_q;
                probe_width_q  <= probe_cnt_q;
                sample_width_q <= sample_cnt_q;
            end
            if (err && error_count_q != 8'hFF) begin
                error_count_q <= error_count_q + 8'd1;
            end
        end
    end

    // Output mapping
    always_comb begin
        pump_width   = pump_width_q;
        mw1_width    = mw1_width_q;
        free_width   = free_width_q;
        mw2_width    = mw2_width_q;
        probe_width  = probe_width_q;
        sample_width = sample_width_q;
        cycle_valid  = cycle_valid_q;
        seq_error    = seq_error_q;
        error_count  = error_count_q;
        fsm_state    = state_q;
    end

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// Bench for pop_sequence_monitor: a 16-bit and an 8-bit counter instance share
// the same stimulus and are checked every cycle against a table-driven model.
module tb_pop_sequence_monitor;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pump_in = 1'b0, probe_in = 1'b0, mw_in = 1'b0, sample_in = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] pw16, m1w16, frw16, m2w16, prw16, smw16;
    logic [7:0]  pw8, m1w8, frw8, m2w8, prw8, smw8;
    logic        cv16, se16, cv8, se8;
    logic [7:0]  ec16, ec8;
    logic [3:0]  st16, st8;

    pop_sequence_monitor #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk(clk), .reset(reset), .pump_in(pump_in), .probe_in(probe_in),
        .MW_in(mw_in), .sample_in(sample_in),
        .pump_width(pw16), .mw1_width(m1w16), .free_width(frw16), .mw2_width(m2w16),
        .probe_width(prw16), .sample_width(smw16), .cycle_valid(cv16),
        .seq_error(se16), .error_count(ec16), .fsm_state(st16)
    );

    pop_sequence_monitor #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .reset(reset), .pump_in(pump_in), .probe_in(probe_in),
        .MW_in(mw_in), .sample_in(sample_in),
        .pump_width(pw8), .mw1_width(m1w8), .free_width(frw8), .mw2_width(m2w8),
        .probe_width(prw8), .sample_width(smw8), .cycle_valid(cv8),
        .seq_error(se8), .error_count(ec8), .fsm_state(st8)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle,1 pump,2 dark,3 mw1,4 free,5 mw2,6 gap,7 detect,8 tail.
    // Vectors {p,r,m}: 4=pump, 2=probe, 1=mw, 0=none. Exit target 9 = complete.
    int unsigned cmax [2]     = '{65535, 255};
    int          stay_v [9]   = '{-1, 4, 0, 1, 0, 1, 0, 2, 0};
    int          t_from [10]  = '{1, 2, 3, 4, 5, 5, 6, 7, 7, 8};
    int          t_vec  [10]  = '{0, 1, 0, 1, 0, 2, 2, 0, 4, 4};
    int          t_to   [10]  = '{2, 3, 4, 5, 6, 7, 7, 8, 9, 9};

    bit [3:0]    hist [SYNC+1];
    int          ph [2];
    int unsigned cnt [2][9];
    int unsigned smp [2];
    int unsigned ew [2][6];
    bit          ev [2], ee [2];
    int unsigned ec [2];

    int          m_v, m_old, m_nxt;
    int unsigned m_oldsmp;
    bit          m_s, m_rise, m_start, m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= SYNC; i++) hist[i] = '0;
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0; smp[k] = 0; ev[k] = 0; ee[k] = 0; ec[k] = 0;
                for (int j = 0; j < 9; j++) cnt[k][j] = 0;
                for (int j = 0; j < 6; j++) ew[k][j] = 0;
            end
        end else begin
            m_v    = int'(hist[SYNC-1][3:1]);
            m_s    = hist[SYNC-1][0];
            m_rise = hist[SYNC-1][3] && !hist[SYNC][3];
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0; ee[k] = 0; m_start = 0; m_err = 0;
                m_old = ph[k]; m_oldsmp = smp[k];
                if (m_old == 0) begin
                    m_start = m_rise && (m_v == 4);
                end else if (m_v == stay_v[m_old]) begin
                    if (cnt[k][m_old] == cmax[k]) m_err = 1;
                    else cnt[k][m_old]++;
                end else begin
                    m_nxt = -1;
                    for (int j = 0; j < 10; j++)
                        if (t_from[j] == m_old && t_vec[j] == m_v) m_nxt = t_to[j];
                    if (m_nxt < 0) m_err = 1;
                    else if (m_nxt == 9) begin
                        ev[k] = 1;
                        ew[k][0] = cnt[k][1]; ew[k][1] = cnt[k][3]; ew[k][2] = cnt[k][4];
                        ew[k][3] = cnt[k][5]; ew[k][4] = cnt[k][7]; ew[k][5] = m_oldsmp;
                        m_start = 1;
                    end else begin
                        ph[k] = m_nxt; cnt[k][m_nxt] = 1;
                    end
                end
                if (m_old != 0 && m_s && smp[k] < cmax[k]) smp[k]++;
                if (m_err) begin
                    ph[k] = 0; ee[k] = 1;
                    if (ec[k] < 255) ec[k]++;
                end
                if (m_start) begin
                    ph[k] = 1;
                    for (int j = 0; j < 9; j++) cnt[k][j] = 0;
                    cnt[k][1] = 1;
                    smp[k] = m_s;
                end
            end
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {pump_in, probe_in, mw_in, sample_in};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] act_w [2][6];
    assign act_w[0][0] = pw16;  assign act_w[0][1] = m1w16; assign act_w[0][2] = frw16;
    assign act_w[0][3] = m2w16; assign act_w[0][4] = prw16; assign act_w[0][5] = smw16;
    assign act_w[1][0] = {8'd0, pw8};  assign act_w[1][1] = {8'd0, m1w8};
    assign act_w[1][2] = {8'd0, frw8}; assign act_w[1][3] = {8'd0, m2w8};
    assign act_w[1][4] = {8'd0, prw8}; assign act_w[1][5] = {8'd0, smw8};

    string wname [6] = '{"pump_width", "mw1_width", "free_width", "mw2_width",
                         "probe_width", "sample_width"};
    int nv [2] = '{0, 0};
    int ne [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("dut%0d.%s", k, wname[i]), act_w[k][i], ew[k][i]);
            check($sformatf("dut%0d.cycle_valid", k), (k == 0) ? cv16 : cv8, ev[k]);
            check($sformatf("dut%0d.seq_error", k), (k == 0) ? se16 : se8, ee[k]);
            check($sformatf("dut%0d.error_count", k), (k == 0) ? ec16 : ec8, ec[k]);
            check($sformatf("dut%0d.fsm_state", k), (k == 0) ? st16 : st8, ph[k]);
        end
        if (cv16) nv[0]++;
        if (cv8)  nv[1]++;
        if (se16) ne[0]++;
        if (se8)  ne[1]++;
    end

    // ---------------- stimulus ----------------
    task automatic seg(input logic [2:0] v, input logic s, input int n);
        {pump_in, probe_in, mw_in} = v;
        sample_in = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic legal(input int pu, input int dk, input int m1, input int fr,
                         input int m2, input int gp, input int pr, input int sl);
        seg(3'b100, 1'b0, pu);
        seg(3'b000, 1'b0, dk);
        seg(3'b001, 1'b0, m1);
        seg(3'b000, 1'b0, fr);
        seg(3'b001, 1'b0, m2);
        if (gp > 0) seg(3'b000, 1'b0, gp);
        if (pr > sl) seg(3'b010, 1'b0, pr - sl);
        if (sl > 0) seg(3'b010, 1'b1, sl);
    endtask

    initial begin
        // Start with MW already high, as if joining mid-sequence
        mw_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset fsm_state", st16, 0);
        check("reset pump_width", pw16, 0);
        check("reset error_count", ec16, 0);
        reset = 1'b0;

        seg(3'b001, 1'b0, 10);
        seg(3'b000, 1'b0, 4);
        seg(3'b010, 1'b1, 6);
        seg(3'b000, 1'b0, 3);
        seg(3'b001, 1'b0, 2);
        seg(3'b000, 1'b0, 5);
        check("midstart no error", ne[0], 0);
        check("midstart no valid", nv[0], 0);

        // Legal cycle, then pump rises
        legal(50, 10, 5, 20, 5, 3, 40, 30);
        seg(3'b100, 1'b0, 19);
        check("c1 valid count", nv[0], 1);
        check("c1 pump", pw16, 50);
        check("c1 mw1", m1w16, 5);
        check("c1 free", frw16, 20);
        check("c1 mw2", m2w16, 5);
        check("c1 probe", prw16, 40);
        check("c1 sample", smw16, 30);
        check("c1 errors", ec16, 0);

        // MW forced high on pump cycle 20
        seg(3'b101, 1'b0, 1);
        seg(3'b000, 1'b0, 8);
        check("err pulses", ne[0], 1);
        check("err count", ec16, 1);
        check("err state idle", st16, 0);
        check("err widths held", pw16, 50);

        // Recovery cycle without gap
        legal(30, 4, 6, 15, 7, 0, 25, 10);
        seg(3'b100, 1'b0, 6);
        check("c2 valid count", nv[0], 2);
        check("c2 pump", pw16, 30);
        check("c2 free", frw16, 15);
        check("c2 probe", prw16, 25);
        check("c2 sample", smw16, 10);

        // Long free precession: 8-bit instance times out, 16-bit keeps going
        seg(3'b000, 1'b0, 5);
        seg(3'b001, 1'b0, 4);
        seg(3'b000, 1'b0, 290);
        check("t8 errors", ec8, 2);
        check("t8 idle", st8, 0);
        check("t8 free held", frw8, 15);
        check("t16 in free", st16, 4);
        seg(3'b000, 1'b0, 10);
        seg(3'b001, 1'b0, 4);
        seg(3'b010, 1'b0, 12);
        seg(3'b100, 1'b0, 6);
        check("t16 valid count", nv[0], 3);
        check("t16 free 300", frw16, 300);
        check("t8 no valid", nv[1], 2);

        // Reset while in FREE
        seg(3'b000, 1'b0, 5);
        seg(3'b001, 1'b0, 4);
        seg(3'b000, 1'b0, 8);
        reset = 1'b1;
        #1;
        check("rst pump_width", pw16, 0);
        check("rst free_width", frw16, 0);
        check("rst error_count8", ec8, 0);
        check("rst fsm_state", st16, 0);
        seg(3'b000, 1'b0, 3);
        reset = 1'b0;
        seg(3'b000, 1'b0, 10);
        seg(3'b001, 1'b0, 4);
        seg(3'b000, 1'b0, 3);
        seg(3'b010, 1'b1, 10);
        check("rst no report", nv[0], 3);

        // Back-to-back cycles with free 20 then 21
        legal(12, 3, 5, 20, 5, 2, 9, 4);
        legal(20, 5, 3, 21, 3, 0, 15, 5);
        check("b2b first valid", nv[0], 4);
        check("b2b free 20", frw16, 20);
        check("b2b sample 4", smw16, 4);
        seg(3'b100, 1'b0, 5);
        check("b2b second valid", nv[0], 5);
        check("b2b free 21", frw16, 21);

        // 260 injected errors, count must saturate
        for (int i = 0; i < 260; i++) begin
            seg(3'b110, 1'b0, 1);
            seg(3'b000, 1'b0, 1);
            seg(3'b100, 1'b0, 1);
        end
        seg(3'b000, 1'b0, 5);
        check("sat count16", ec16, 255);
        check("sat count8", ec8, 255);
        check("sat widths held", frw16, 21);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pop_sequence_monitor.md
Name: pop_sequence_monitor

Overview:
- Receive-side checker for the POP timing outputs: pump, probe, MW, sample.
- Follows the pulse train through a phase FSM and measures each phase width in clk cycles.
- Flags any illegal signal combination or phase timeout.
- Latches a complete set of widths once per good cycle so firmware, or a second board, can confirm the pi/2 and free-precession settings.

Parameters:
- CNT_W, 16, width of every phase counter and width output (65535 cycles = 26 ms at 2.5 MHz).
- SYNC_STAGES, 2, flip-flop stages on each input (minimum 2).

Ports:
- clk  input  1  2.5 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- pump_in  input  1  pump line, asynchronous to clk.
- probe_in  input  1  probe line.
- MW_in  input  1  microwave line.
- sample_in  input  1  sample/gate line.
- pump_width  output  CNT_W  latched pump-high cycles.
- mw1_width  output  CNT_W  first pi/2 pulse width.
- free_width  output  CNT_W  free-precession (MW low between pulses) width.
- mw2_width  output  CNT_W  second pi/2 pulse width.
- probe_width  output  CNT_W  probe-high width.
- sample_width  output  CNT_W  sample-high cycles counted since the pump rising edge.
- cycle_valid  output  1  one-cycle pulse; width outputs just updated.
- seq_error  output  1  one-cycle pulse on each detected violation.
- error_count  output  8  saturating violation count.
- fsm_state  output  4  current state encoding, for debug/LED.

Behaviour:
- Reset: every output 0, synchronizers 0, FSM IDLE, internal counters 0.
- Inputs: pass through SYNC_STAGES flops. All decisions use the synchronized values p, r, m, s and the previous synchronized pump.
- Vector V = {p, r, m}. sample is never checked for legality; it is only counted.
- States, with encoding:
  - IDLE=0: wait for p rising with V=100, then go to PUMP with pump_cnt=1. All other vectors are ignored, with no error, so startup mid-cycle is silent.
  - PUMP=1: 100 stay, pump_cnt++. 000 go to DARK. Else error.
  - DARK=2: 000 stay. 001 go to MW1 with mw1_cnt=1. Else error.
  - MW1=3: 001 stay, mw1_cnt++. 000 go to FREE with free_cnt=1. Else error.
  - FREE=4: 000 stay, free_cnt++. 001 go to MW2 with mw2_cnt=1. Else error.
  - MW2=5: 001 stay, mw2_cnt++. 000 go to GAP. 010 go to DETECT with probe_cnt=1. Else error.
  - GAP=6: 000 stay. 010 go to DETECT with probe_cnt=1. Else error.
  - DETECT=7: 010 stay, probe_cnt++. 000 go to TAIL. 100 means cycle complete. Else error.
  - TAIL=8: 000 stay. 100 means cycle complete. Else error.
- Entry cycle rule: the cycle of entry counts as 1, so a width equals the number of cycles the pattern was held.
- sample_cnt: cleared to 0 whenever the pump-rising transition from IDLE/DETECT/TAIL is taken. That clear is overridden to 1 when s=1 on that edge cycle. On all other cycles sample_cnt increments whenever s=1 in PUMP through TAIL.
- Cycle complete:
  - On the clk edge where the complete transition is taken, copy all six counters to the outputs.
  - Assert cycle_valid for exactly the following cycle.
  - FSM goes to PUMP with pump_cnt=1 and other counters cleared.
  - Latency: raw pump edge to cycle_valid high = SYNC_STAGES+1 cycles.
- Error:
  - seq_error high for one cycle. error_count++ and saturates at 255.
  - FSM goes to IDLE. Width outputs are held. No cycle_valid.
- Timeout: if the active phase counter (including a DARK/GAP/TAIL dwell counter) would exceed 2^CNT_W−1, treat it as an error at that cycle. Counters never wrap.
- Simultaneous events: error takes priority over completion; only one of cycle_valid/seq_error can assert per cycle.
- Reset mid-operation: immediate return to reset values. The next cycle is reported only after a fresh pump rising edge and a full sequence.

Test Plan:
1. Legal cycle (pump 50, dark 10, MW 5, free 20, MW 5, gap 3, probe 40 with sample high for the last 30, then pump rises) -> one cycle_valid; widths 50/5/20/5/40/30; error_count 0.
2. MW_in forced high on cycle 20 of pump -> seq_error one pulse; error_count=1; fsm_state=0; prior widths unchanged; next legal cycle reports correctly.
3. CNT_W=8, free precession held 300 cycles -> seq_error when free_cnt would exceed 255; no wrap; FSM IDLE.
4. Bench starts with MW_in high mid-sequence -> no seq_error; first cycle_valid only after a pump edge plus a full legal sequence.
5. Reset asserted in FREE, released 3 cycles later -> all outputs 0 immediately; the next report requires a full new cycle.
6. Back-to-back cycles with free = 20 then 21, then 260 injected errors -> two cycle_valid pulses reporting 20 then 21; error_count stops at 255.
